// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter
//   Two-requester round-robin arbiter merging two valid/ack word streams
//   into one registered output stream tagged with the source port.
//   Bursts of up to MAX_BURST words are granted while the other side waits;
//   a one-cycle arbitration bubble follows IDLE.
//
// Parameters
//   PAYLOAD_BITS  data word width
//   NUM_PORT_BITS port tag width
//   PORT_BASE     tag for requester 0 (requester 1 emits PORT_BASE+1)
//   MAX_BURST     max consecutive words per grant while the other waits (1..15)
//
// Ports
//   clk_user            clock, rising edge
//   reset_n             synchronous active-low reset
//   din_0/din_1         requester data
//   vld_0/vld_1         requester valid
//   ack_0/ack_1         word accepted from requester (combinational)
//   dout/dout_port      output word and its source tag
//   vld_out             output register holds a word
//   ack_in              downstream accepted the output word
//   grant_cnt_0/1       accepted-word counters (only with LEAF_OUT_ARBITER_STATS_EN)
//
// Build option
//   `define LEAF_OUT_ARBITER_STATS_EN adds the grant_cnt_0/1 ports and counters.
module leaf_out_arbiter #(
  parameter int unsigned PAYLOAD_BITS  = 32,
  parameter int unsigned NUM_PORT_BITS = 4,
  parameter int unsigned PORT_BASE     = 1,
  parameter int unsigned MAX_BURST     = 4
) (
  input  logic                     clk_user,
  input  logic                     reset_n,
  input  logic [PAYLOAD_BITS-1:0]  din_0,
  input  logic [PAYLOAD_BITS-1:0]  din_1,
  input  logic                     vld_0,
  input  logic                     vld_1,
  output logic                     ack_0,
  output logic                     ack_1,
  output logic [PAYLOAD_BITS-1:0]  dout,
  output logic [NUM_PORT_BITS-1:0] dout_port,
  output logic                     vld_out,
  input  logic                     ack_in
`ifdef LEAF_OUT_ARBITER_STATS_EN
  ,
  output logic [31:0]              grant_cnt_0,
  output logic [31:0]              grant_cnt_1
`endif
);

  localparam logic [NUM_PORT_BITS-1:0] TAG0      = NUM_PORT_BITS'(PORT_BASE);
  localparam logic [NUM_PORT_BITS-1:0] TAG1      = NUM_PORT_BITS'(PORT_BASE + 1);
  localparam logic [3:0]               BURST_LIM = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] burst_cnt, burst_cnt_nxt;
  logic [3:0] burst_inc;
  logic       last_served, last_served_nxt;
  logic       load_ok;

  // Output register can take a new word when empty or being drained this cycle.
  assign load_ok = ~vld_out | ack_in;

  // Acks depend only on registered state, so a requester is never accepted
  // in the cycle it first raises vld from IDLE.
  assign ack_0 = reset_n & (state == GRANT0) & vld_0 & load_ok;
  assign ack_1 = reset_n & (state == GRANT1) & vld_1 & load_ok;

  assign burst_inc = burst_cnt + 4'd1;

  always_comb begin
    state_nxt       = state;
    burst_cnt_nxt   = burst_cnt;
    last_served_nxt = last_served;
    case (state)
      IDLE: begin
        burst_cnt_nxt = '0;
        if (vld_0 && vld_1) state_nxt = last_served ? GRANT0 : GRANT1;
        else if (vld_0)     state_nxt = GRANT0;
        else if (vld_1)     state_nxt = GRANT1;
      end
      GRANT0: begin
        if (!vld_0) begin
          state_nxt     = vld_1 ? GRANT1 : IDLE;
          burst_cnt_nxt = '0;
        end else if (ack_0) begin
          last_served_nxt = 1'b0;
          if (burst_inc == BURST_LIM) begin
            // Burst exhausted: hand over only if the other side is waiting,
            // otherwise start a fresh burst in place.
            burst_cnt_nxt = '0;
            if (vld_1) state_nxt = GRANT1;
          end else begin
            burst_cnt_nxt = burst_inc;
          end
        end
      end
      GRANT1: begin
        if (!vld_1) begin
          state_nxt     = vld_0 ? GRANT0 : IDLE;
          burst_cnt_nxt = '0;
        end else if (ack_1) begin
          last_served_nxt = 1'b1;
          if (burst_inc == BURST_LIM) begin
            burst_cnt_nxt = '0;
            if (vld_0) state_nxt = GRANT0;
          end else begin
            burst_cnt_nxt = burst_inc;
          end
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_user) begin
    if (!reset_n) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      last_served <= 1'b1;
    end else begin
      state       <= state_nxt;
      burst_cnt   <= burst_cnt_nxt;
      last_served <= last_served_nxt;
    end
  end

  always_ff @(posedge clk_user) begin
    if (!reset_n) begin
      vld_out   <= 1'b0;
      dout      <= '0;
      dout_port <= '0;
    end else if (ack_0) begin
      vld_out   <= 1'b1;
      dout      <= din_0;
      dout_port <= TAG0;
    end else if (ack_1) begin
      vld_out   <= 1'b1;
      dout      <= din_1;
      dout_port <= TAG1;
    end else if (ack_in) begin
      vld_out   <= 1'b0;
    end
  end

`ifdef LEAF_OUT_ARBITER_STATS_EN
  always_ff @(posedge clk_user) begin
    if (!reset_n) begin
      grant_cnt_0 <= '0;
      grant_cnt_1 <= '0;
    end else begin
      if (ack_0) grant_cnt_0 <= grant_cnt_0 + 32'd1;
      if (ack_1) grant_cnt_1 <= grant_cnt_1 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb_leaf_out_arbiter
//   Directed bench for leaf_out_arbiter (PAYLOAD_BITS=32, NUM_PORT_BITS=4,
//   PORT_BASE=1, MAX_BURST=4). Inputs change on the falling edge; outputs are
//   checked 1 ns later, well before the next rising edge.
module tb_leaf_out_arbiter;

  logic        clk_user = 1'b0;
  logic        reset_n;
  logic [31:0] din_0, din_1;
  logic        vld_0, vld_1;
  logic        ack_0, ack_1;
  logic [31:0] dout;
  logic [3:0]  dout_port;
  logic        vld_out;
  logic        ack_in;
`ifdef LEAF_OUT_ARBITER_STATS_EN
  logic [31:0] grant_cnt_0, grant_cnt_1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_user = ~clk_user;

  leaf_out_arbiter #(
    .PAYLOAD_BITS (32),
    .NUM_PORT_BITS(4),
    .PORT_BASE    (1),
    .MAX_BURST    (4)
  ) dut (
    .clk_user (clk_user),
    .reset_n  (reset_n),
    .din_0    (din_0),
    .din_1    (din_1),
    .vld_0    (vld_0),
    .vld_1    (vld_1),
    .ack_0    (ack_0),
    .ack_1    (ack_1),
    .dout     (dout),
    .dout_port(dout_port),
    .vld_out  (vld_out),
    .ack_in   (ack_in)
`ifdef LEAF_OUT_ARBITER_STATS_EN
    ,
    .grant_cnt_0(grant_cnt_0),
    .grant_cnt_1(grant_cnt_1)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_user);
    @(negedge clk_user);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    vld_0   = 1'b0;
    vld_1   = 1'b0;
    ack_in  = 1'b1;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, g, r, k, j;
    logic a0, a1;
    logic [1:0] exp_ack;

    reset_n = 1'b0;
    vld_0 = 1'b0; vld_1 = 1'b0; ack_in = 1'b1;
    din_0 = '0; din_1 = '0;
    @(negedge clk_user);
    do_reset();

    // Reset state
    #1;
    check_eq("rst_vld_out", vld_out, 0);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_dout_port", dout_port, 0);
    check_eq("rst_acks", {ack_1, ack_0}, 2'b00);
`ifdef LEAF_OUT_ARBITER_STATS_EN
    check_eq("rst_cnt0", grant_cnt_0, 0);
    check_eq("rst_cnt1", grant_cnt_1, 0);
`endif

    // Single requester, one bubble then one word per cycle
    @(negedge clk_user);
    vld_0 = 1'b1; din_0 = 32'h11;
    #1 check_eq("t1_bubble_ack0", ack_0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      din_0 = 32'h11 + i;
      #1;
      check_eq("t1_ack0", ack_0, 1);
      if (i > 0) begin
        check_eq("t1_dout", dout, 32'h11 + i - 1);
        check_eq("t1_port", dout_port, 1);
        check_eq("t1_vld_out", vld_out, 1);
      end else begin
        check_eq("t1_vld_out0", vld_out, 0);
      end
      step();
    end
    vld_0 = 1'b0;
    #1;
    check_eq("t1_last_dout", dout, 32'h14);
    check_eq("t1_last_port", dout_port, 1);
    check_eq("t1_last_ack0", ack_0, 0);
`ifdef LEAF_OUT_ARBITER_STATS_EN
    check_eq("t1_cnt0", grant_cnt_0, 4);
    check_eq("t1_cnt1", grant_cnt_1, 0);
`endif
    step();
    #1 check_eq("t1_drained", vld_out, 0);
    @(negedge clk_user);

    // Both requesters continuous: ports 1,1,1,1,2,2,2,2,...
    do_reset();
    n0 = 0; n1 = 0;
    vld_0 = 1'b1; vld_1 = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      din_0 = 32'h100 + n0;
      din_1 = 32'h200 + n1;
      #1;
      if (c == 0) exp_ack = 2'b00;
      else begin
        r = ((c - 1) / 4) % 2;
        exp_ack = (r == 1) ? 2'b10 : 2'b01;
      end
      check_eq("t2_acks", {ack_1, ack_0}, exp_ack);
      if (c >= 2) begin
        k = c - 1;
        g = (k - 1) / 4;
        r = g % 2;
        j = (g / 2) * 4 + (k - 1) % 4;
        check_eq("t2_vld_out", vld_out, 1);
        check_eq("t2_port", dout_port, 1 + r);
        check_eq("t2_dout", dout, ((r == 1) ? 32'h200 : 32'h100) + j);
      end
      a0 = ack_0; a1 = ack_1;
      step();
      if (a0) n0++;
      if (a1) n1++;
    end
    vld_0 = 1'b0; vld_1 = 1'b0;
    #1;
    check_eq("t2_final_dout", dout, 32'h207);
    check_eq("t2_final_port", dout_port, 2);
`ifdef LEAF_OUT_ARBITER_STATS_EN
    check_eq("t2_cnt0", grant_cnt_0, 8);
    check_eq("t2_cnt1", grant_cnt_1, 8);
`endif
    @(negedge clk_user);

    // Backpressure holds the output word and blocks acks
    do_reset();
    vld_0 = 1'b1; din_0 = 32'hA5A5A5A5;
    #1 check_eq("t3_bubble_ack0", ack_0, 0);
    step();
    #1 check_eq("t3_ack0_first", ack_0, 1);
    step();
    ack_in = 1'b0; din_0 = 32'h5A5A5A5A;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("t3_hold_dout", dout, 32'hA5A5A5A5);
      check_eq("t3_hold_vld", vld_out, 1);
      check_eq("t3_hold_acks", {ack_1, ack_0}, 2'b00);
      step();
    end
    ack_in = 1'b1;
    #1;
    check_eq("t3_release_ack0", ack_0, 1);
    check_eq("t3_release_dout", dout, 32'hA5A5A5A5);
    step();
    vld_0 = 1'b0;
    #1;
    check_eq("t3_next_dout", dout, 32'h5A5A5A5A);
    check_eq("t3_next_vld", vld_out, 1);
    step();
    #1 check_eq("t3_drained", vld_out, 0);
    @(negedge clk_user);

    // Requester 1 drops vld mid-burst: direct handover to requester 0
    do_reset();
    vld_1 = 1'b1; din_1 = 32'h301;
    #1 check_eq("t4_bubble_ack1", ack_1, 0);
    step();
    #1 check_eq("t4_acks_w0", {ack_1, ack_0}, 2'b10);
    step();
    din_1 = 32'h302; vld_0 = 1'b1; din_0 = 32'h401;
    #1 check_eq("t4_acks_w1", {ack_1, ack_0}, 2'b10);
    step();
    vld_1 = 1'b0;
    #1;
    check_eq("t4_drop_acks", {ack_1, ack_0}, 2'b00);
    check_eq("t4_drop_dout", dout, 32'h302);
    check_eq("t4_drop_port", dout_port, 2);
    step();
    #1 check_eq("t4_switch_acks", {ack_1, ack_0}, 2'b01);
    step();
    vld_0 = 1'b0;
    #1;
    check_eq("t4_sw_dout", dout, 32'h401);
    check_eq("t4_sw_port", dout_port, 1);
    check_eq("t4_sw_vld", vld_out, 1);
    @(negedge clk_user);

    // Reset mid-burst: word discarded, tie then goes to requester 0
    do_reset();
    vld_0 = 1'b1; din_0 = 32'h501;
    #1 check_eq("t5_bubble_ack0", ack_0, 0);
    step();
    #1 check_eq("t5_ack0", ack_0, 1);
    step();
    din_0 = 32'h502; reset_n = 1'b0;
    #1;
    check_eq("t5_rst_ack_forced", {ack_1, ack_0}, 2'b00);
    check_eq("t5_pre_vld", vld_out, 1);
    step();
    reset_n = 1'b1; vld_1 = 1'b1; din_1 = 32'h601;
    #1;
    check_eq("t5_post_vld", vld_out, 0);
    check_eq("t5_post_dout", dout, 0);
    check_eq("t5_post_port", dout_port, 0);
    check_eq("t5_post_acks", {ack_1, ack_0}, 2'b00);
`ifdef LEAF_OUT_ARBITER_STATS_EN
    check_eq("t5_cnt0", grant_cnt_0, 0);
    check_eq("t5_cnt1", grant_cnt_1, 0);
`endif
    step();
    #1 check_eq("t5_tie_acks", {ack_1, ack_0}, 2'b01);
    step();
    #1;
    check_eq("t5_tie_dout", dout, 32'h502);
    check_eq("t5_tie_port", dout_port, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/leaf_out_arbiter.md
LEAF_OUT_ARBITER -- requirements
Module: leaf_out_arbiter

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 32, meaning width of each data word.
REQ-002 SHALL have parameter NUM_PORT_BITS, default 4, meaning width of the port tag.
REQ-003 SHALL have parameter PORT_BASE, default 1, meaning tag emitted for requester 0; requester 1 emits PORT_BASE+1.
REQ-004 SHALL have parameter MAX_BURST, default 4, range 1..15, meaning maximum consecutive words per grant while the other requester waits.
REQ-005 SHALL have port clk_user  in  1  single clock; all logic on the rising edge.
REQ-006 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-007 SHALL have ports din_0/din_1  in  PAYLOAD_BITS  requester data.
REQ-008 SHALL have ports vld_0/vld_1  in  1  requester valid; ack_0/ack_1  out  1  word accepted.
REQ-009 SHALL have ports dout  out  PAYLOAD_BITS, dout_port  out  NUM_PORT_BITS, vld_out  out  1, ack_in  in  1 (merged stream toward leaf interface).
REQ-010 SHALL have ports grant_cnt_0/grant_cnt_1  out  32  accepted-word counters, present only under ARB_STATS_EN.

Function
REQ-011 SHALL treat a transfer on any vld/ack pair as occurring on a cycle where both are 1.
REQ-012 SHALL hold one-entry output register (dout, dout_port, vld_out); loadable when vld_out=0 or ack_in=1.
REQ-013 SHALL drive ack_k = (state==GRANTk) & vld_k & (~vld_out | ack_in), combinationally; at most one ack high per cycle.
REQ-014 SHALL capture din_k and tag into the output register on the cycle ack_k=1; vld_out=1 next cycle (latency 1).
REQ-015 SHALL clear vld_out after ack_in=1 unless a new word is captured the same cycle (back-to-back, one word per cycle sustained).
REQ-016 SHALL keep dout/dout_port stable while vld_out=1 and ack_in=0.
REQ-017 SHALL implement FSM states IDLE, GRANT0, GRANT1.
REQ-018 IDLE: only vld_0 -> GRANT0; only vld_1 -> GRANT1; both -> requester other than last_served; none -> IDLE.
REQ-019 GRANTk: SHALL count transfers in burst_cnt (reset to 0 on entry).
REQ-020 GRANTk: vld_k=0 -> other requester's GRANT if its vld=1, else IDLE.
REQ-021 GRANTk: transfer making burst_cnt reach MAX_BURST with other vld=1 -> other GRANT next cycle; with other vld=0 -> stay, burst_cnt cleared.
REQ-022 SHALL update last_served to k on every transfer from requester k.
REQ-023 SHALL never drop or duplicate a word; requester order preserved per requester.
REQ-024 SHALL make the grant decision from registered state only; a requester raising vld is never acked in that same cycle from IDLE (one-cycle arbitration bubble).

Reset
REQ-025 SHALL on reset_n=0 at a clock edge set state=IDLE, vld_out=0, dout=0, dout_port=0, burst_cnt=0, last_served=1 (requester 0 wins first tie).
REQ-026 SHALL force ack_0=ack_1=0 while reset_n=0; a word held mid-operation is discarded.
REQ-027 SHALL clear grant counters on reset when ARB_STATS_EN defined.

Configuration
REQ-028 With macro LEAF_OUT_ARBITER_STATS_EN defined, SHALL instantiate grant_cnt_0/1, incrementing on each ack_k transfer, wrapping 0xFFFFFFFF->0.
REQ-029 Without LEAF_OUT_ARBITER_STATS_EN, SHALL omit grant_cnt ports and counter logic entirely; all other behaviour identical.

Verification
REQ-030 Single requester: vld_0=1 with din_0=0x11..0x14, ack_in=1 -> dout sequence 0x11..0x14, dout_port=1, one word per cycle after one-cycle bubble.
REQ-031 Both requesters continuous, MAX_BURST=4, ack_in=1 -> dout_port pattern 1,1,1,1,2,2,2,2,1,... first word from requester 0.
REQ-032 Backpressure: ack_in=0 for 5 cycles while vld_out=1 with dout=0xA5A5A5A5 -> dout stable, ack_0=ack_1=0, no loss after ack_in returns.
REQ-033 Requester 1 drops vld after 2 words in GRANT1 with vld_0=1 -> switch to GRANT0 next cycle, no idle cycle in IDLE.
REQ-034 Reset_n=0 for one cycle mid-burst with vld_out=1 -> next cycle vld_out=0, state IDLE, grant_cnt_0/1=0 (STATS build), first subsequent tie granted to requester 0.
